// File: rtl/sram_1rw_masked_init.sv
// Parametrised 1RW synchronous SRAM model with per-lane write mask, optional
// output register and a reset-driven initialisation sweep signalled by BUSY.
module sram_1rw_masked_init #(
    parameter int unsigned       DEPTH     = 1024,
    parameter int unsigned       WIDTH     = 38,
    parameter int unsigned       MASK_GRAN = 8,
    parameter int unsigned       ADDR_W    = $clog2(DEPTH),
    parameter int unsigned       OUT_REG   = 0,
    parameter logic [WIDTH-1:0]  INIT_VAL  = '0
) (
    input  logic                                   CE,
    input  logic                                   RSTB,
    input  logic                                   CSB,
    input  logic                                   WEB,
    input  logic                                   OEB,
    input  logic [ADDR_W-1:0]                      A,
    input  logic [WIDTH-1:0]                       I,
    input  logic [(WIDTH+MASK_GRAN-1)/MASK_GRAN-1:0] M,
    output logic [WIDTH-1:0]                       O,
    output logic                                   O_VALID,
    output logic                                   BUSY
);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic               w_last;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_re;
    logic               w_we;
    logic               w_in_range;
    logic [WIDTH-1:0]   w_rd_data;
    logic [WIDTH-1:0]   w_bmask;

    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [WIDTH-1:0]   w_wr_data;
    logic [WIDTH-1:0]   w_wr_mask;

    logic [WIDTH-1:0]   r_o;
    logic               r_o_valid;

    assign w_last     = (r_cnt == ADDR_W'(DEPTH - 1));
    assign w_re       = (r_state == S_IDLE) && !CSB && !OEB;
    assign w_we       = (r_state == S_IDLE) && !CSB && !WEB;
    assign w_in_range = ({1'b0, A} < (ADDR_W + 1)'(DEPTH));
    assign w_rd_data  = w_in_range ? r_mem[A] : '0;

    always_ff @(posedge CE) begin
        if (!RSTB) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && w_last) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge CE) begin
        if (!RSTB) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= w_last ? '0 : r_cnt + ADDR_W'(1);
        end
    end

    // Expand the lane mask to one enable per data bit; the last lane may be partial.
    always_comb begin
        w_bmask = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            w_bmask[b] = M[b / MASK_GRAN];
        end
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = A;
        w_wr_data = I;
        w_wr_mask = w_bmask;
        if (RSTB) begin
            if (r_state == S_INIT) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = INIT_VAL;
                w_wr_mask = '1;
            end else if (w_we && w_in_range) begin
                w_wr_en = 1'b1;
            end
        end
    end

    // Read data is taken from the pre-edge array, giving read-before-write.
    always_ff @(posedge CE) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= (r_mem[w_wr_addr] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            always_ff @(posedge CE) begin
                if (!RSTB) begin
                    r_o       <= '0;
                    r_o_valid <= 1'b0;
                end else begin
                    r_o_valid <= w_re;
                    if (w_re) begin
                        r_o <= w_rd_data;
                    end
                end
            end
        end else begin : g_piped
            logic [WIDTH-1:0] r_p_data;
            logic             r_p_valid;

            always_ff @(posedge CE) begin
                if (!RSTB) begin
                    r_p_data  <= '0;
                    r_p_valid <= 1'b0;
                    r_o       <= '0;
                    r_o_valid <= 1'b0;
                end else begin
                    r_p_valid <= w_re;
                    if (w_re) begin
                        r_p_data <= w_rd_data;
                    end
                    r_o_valid <= r_p_valid;
                    if (r_p_valid) begin
                        r_o <= r_p_data;
                    end
                end
            end
        end
    endgenerate

    assign O       = r_o;
    assign O_VALID = r_o_valid;
    assign BUSY    = (r_state == S_INIT);

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Scoreboard bench: two SRAM instances (DEPTH=12 direct output, DEPTH=16
// registered output) share one directed stimulus stream.
module tb_sram_1rw_masked_init;

    typedef struct {
        logic [37:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstb, csb, web, oeb;
    logic [3:0]  a;
    logic [37:0] din;
    logic [4:0]  m;
    logic [37:0] o0, o1;
    logic        ov0, ov1, busy0, busy1;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1rw_masked_init #(
        .DEPTH(12), .WIDTH(38), .MASK_GRAN(8), .OUT_REG(0), .INIT_VAL(38'h15)
    ) u0 (
        .CE(clk), .RSTB(rstb), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .M(m),
        .O(o0), .O_VALID(ov0), .BUSY(busy0)
    );

    sram_1rw_masked_init #(
        .DEPTH(16), .WIDTH(38), .MASK_GRAN(8), .OUT_REG(1), .INIT_VAL(38'h15)
    ) u1 (
        .CE(clk), .RSTB(rstb), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .M(m),
        .O(o1), .O_VALID(ov1), .BUSY(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every O_VALID pulse must match the oldest outstanding read, at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("u0 unexpected O_VALID", 64'(o0), 64'hDEAD_0000);
            end else begin
                e = q0.pop_front();
                chk("u0 read data", 64'(o0), 64'(e.d));
                chk("u0 read cycle", 64'(cyc), 64'(e.c));
            end
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("u1 unexpected O_VALID", 64'(o1), 64'hDEAD_0001);
            end else begin
                e = q1.pop_front();
                chk("u1 read data", 64'(o1), 64'(e.d));
                chk("u1 read cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic r,
                         input logic [3:0] ad, input logic [37:0] d, input logic [4:0] mk);
        csb = c; web = w; oeb = r; a = ad; din = d; m = mk;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 4'd0, 38'h0, 5'h0);
    endtask

    task automatic wr(input logic [3:0] ad, input logic [37:0] d, input logic [4:0] mk);
        drive(1'b0, 1'b0, 1'b1, ad, d, mk);
        tick();
    endtask

    // Issue one read; the expected word for each instance is pushed only if a pulse is due.
    task automatic rd(input logic [3:0] ad, input logic [37:0] e0, input logic [37:0] e1,
                      input bit p0, input bit p1);
        exp_t e;
        drive(1'b0, 1'b1, 1'b0, ad, 38'h0, 5'h0);
        if (p0) begin e.d = e0; e.c = cyc + 1; q0.push_back(e); end
        if (p1) begin e.d = e1; e.c = cyc + 2; q1.push_back(e); end
        tick();
    endtask

    task automatic wait_sweep(input string nm, input int exp0, input int exp1, input bit wr_busy);
        int f0 = 0;
        int f1 = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (wr_busy && k == 11) idle();
            if (f0 == 0 && busy0 == 1'b0) f0 = k;
            if (f1 == 0 && busy1 == 1'b0) f1 = k;
        end
        chk({nm, " u0 busy edges"}, 64'(f0), 64'(exp0));
        chk({nm, " u1 busy edges"}, 64'(f1), 64'(exp1));
    endtask

    initial begin
        rstb = 1'b0;
        idle();
        repeat (3) tick();
        chk("reset u0 O", 64'(o0), 64'h0);
        chk("reset u1 O", 64'(o1), 64'h0);
        chk("reset u0 O_VALID", 64'(ov0), 64'h0);
        chk("reset u1 O_VALID", 64'(ov1), 64'h0);
        chk("reset u0 BUSY", 64'(busy0), 64'h1);
        chk("reset u1 BUSY", 64'(busy1), 64'h1);

        // Abort the first sweep after nine writes.
        rstb = 1'b1;
        repeat (9) tick();
        chk("mid-sweep u0 BUSY", 64'(busy0), 64'h1);
        chk("mid-sweep u1 BUSY", 64'(busy1), 64'h1);
        rstb = 1'b0;
        repeat (2) tick();

        // Full restart; a write/read to A=3 is held during the sweep and must be ignored.
        rstb = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd3, 38'h3F_FFFF_FFFF, 5'h1F);
        wait_sweep("restart", 12, 16, 1'b1);

        // Every address: u0 beyond DEPTH=12 returns 0, u1 holds INIT_VAL everywhere.
        for (int k = 0; k < 16; k++) begin
            rd(4'(k), (k < 12) ? 38'h15 : 38'h0, 38'h15, 1'b1, 1'b1);
        end
        idle();
        repeat (3) tick();

        wr(4'd5, 38'h3F_FFFF_FFFF, 5'b10101);
        rd(4'd5, 38'h3F_00FF_00FF, 38'h3F_00FF_00FF, 1'b1, 1'b1);
        idle();
        tick();

        // Read-before-write on the same edge.
        wr(4'd7, 38'hAA, 5'h1F);
        drive(1'b0, 1'b0, 1'b0, 4'd7, 38'h55, 5'h1F);
        begin
            exp_t e;
            e.d = 38'hAA; e.c = cyc + 1; q0.push_back(e);
            e.d = 38'hAA; e.c = cyc + 2; q1.push_back(e);
        end
        tick();
        rd(4'd7, 38'h55, 38'h55, 1'b1, 1'b1);
        idle();
        tick();

        // Out-of-range write on u0 must be dropped and must not alias onto a real word.
        wr(4'd13, 38'h3F_FFFF_FFFF, 5'h1F);
        rd(4'd13, 38'h0, 38'h3F_FFFF_FFFF, 1'b1, 1'b1);
        rd(4'd1, 38'h15, 38'h15, 1'b1, 1'b1);
        rd(4'd5, 38'h3F_00FF_00FF, 38'h3F_00FF_00FF, 1'b1, 1'b1);
        idle();
        tick();

        // Back-to-back reads, then O must hold the last word with O_VALID low.
        wr(4'd1, 38'h11, 5'h1F);
        wr(4'd2, 38'h22, 5'h1F);
        wr(4'd3, 38'h33, 5'h1F);
        rd(4'd1, 38'h11, 38'h11, 1'b1, 1'b1);
        rd(4'd2, 38'h22, 38'h22, 1'b1, 1'b1);
        rd(4'd3, 38'h33, 38'h33, 1'b1, 1'b1);
        idle();
        repeat (4) tick();
        chk("hold u0 O", 64'(o0), 64'h33);
        chk("hold u1 O", 64'(o1), 64'h33);
        chk("hold u0 O_VALID", 64'(ov0), 64'h0);
        chk("hold u1 O_VALID", 64'(ov1), 64'h0);

        // An all-zero mask is a no-op write.
        wr(4'd2, 38'hFF, 5'h00);
        rd(4'd2, 38'h22, 38'h22, 1'b1, 1'b1);
        idle();
        tick();

        // Reset on the edge after a read: u1's pending result must vanish.
        rd(4'd2, 38'h22, 38'h0, 1'b1, 1'b0);
        idle();
        rstb = 1'b0;
        tick();
        chk("rst-read u0 O", 64'(o0), 64'h0);
        chk("rst-read u1 O", 64'(o1), 64'h0);
        chk("rst-read u1 O_VALID", 64'(ov1), 64'h0);
        chk("rst-read u1 BUSY", 64'(busy1), 64'h1);
        tick();
        rstb = 1'b1;
        wait_sweep("final", 12, 16, 1'b0);
        chk("final u1 O", 64'(o1), 64'h0);

        chk("u0 queue drained", 64'(q0.size()), 64'h0);
        chk("u1 queue drained", 64'(q1.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_1rw_masked_init.md
Name: sram_1rw_masked_init

Overview:
Parametrised single-port (1RW) synchronous SRAM behavioural model. It is the generalised successor of the fixed-size 1RW macro models in the tech cache. Over those models it adds:
- configurable depth and width
- per-lane write mask
- optional output register stage
- a reset-driven hardware initialisation sweep with a BUSY indication, which replaces random simulation initialisation

It sits under the cache/tag/data array wrappers and is the simulation view for any generated macro size.

Parameters:
DEPTH, 1024, number of words; any value ≥ 2, not necessarily a power of two
WIDTH, 38, bits per word
MASK_GRAN, 8, bits per write-mask lane; NL = ceil(WIDTH/MASK_GRAN) lanes, the last lane may be partial
ADDR_W, clog2(DEPTH), address width (derived; do not override)
OUT_REG, 0, 0 = read data after 1 edge; 1 = extra output register, data after 2 edges
INIT_VAL, 0, WIDTH-bit value written to every word by the init sweep

Ports:
CE  input  1  clock; all state changes on posedge CE
RSTB  input  1  synchronous active-low reset
CSB  input  1  chip select, active low
WEB  input  1  write enable, active low
OEB  input  1  read/output enable, active low
A  input  ADDR_W  word address
I  input  WIDTH  write data
M  input  NL  write lane mask, active high; bit k covers I/memory bits [min(WIDTH,(k+1)*MASK_GRAN)-1 : k*MASK_GRAN]
O  output  WIDTH  read data; holds its value between reads
O_VALID  output  1  one-cycle pulse aligned with each new O value
BUSY  output  1  init sweep in progress; requests are ignored while high

Behaviour:
- Reset (RSTB=0 at posedge CE):
  - O=0, O_VALID=0, BUSY=1.
  - Init counter cleared to 0; state forced to INIT.
  - Output pipeline flushed; no memory write occurs.
- FSM states: INIT, IDLE.
- INIT state:
  - Each posedge with RSTB=1 writes INIT_VAL to mem[cnt], then cnt increments.
  - On the edge that writes mem[DEPTH-1], state goes to IDLE and BUSY goes to 0.
  - BUSY is therefore high for exactly DEPTH edges after reset release.
  - CSB/WEB/OEB/A/I/M are ignored; O holds and O_VALID stays 0.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release. Memory contents are undefined until the sweep completes.
- IDLE request decode (at posedge CE):
  - RE = !CSB & !OEB
  - WE = !CSB & !WEB
  - CSB=1 means no operation.
- Write (WE, A<DEPTH): for each lane k with M[k]=1, mem[A] lane k ← I lane k. Lanes with M[k]=0 are unchanged. M=0 is a legal no-op write.
- Read (RE, A<DEPTH):
  - OUT_REG=0: O=mem[A] after the same edge.
  - OUT_REG=1: O=mem[A] after the next edge.
  - O_VALID is high for exactly the one cycle in which the new O first appears.
  - Back-to-back reads give one result per cycle, with O_VALID held high continuously.
- Simultaneous RE and WE to the same address: read-before-write. O returns the old word; the new data is visible to the next read.
- Address A ≥ DEPTH (non-power-of-two DEPTH):
  - Write is dropped.
  - Read returns O=0 with O_VALID=1.
- O retains the last read value indefinitely and is never cleared except by reset.
- No combinational path from any input to O, O_VALID or BUSY.
- Reset mid-read with OUT_REG=1: the pending result is discarded; no O_VALID pulse follows.

Test Plan:
1. Init sweep: DEPTH=16, INIT_VAL=0x15, RSTB low 3 cycles then high → BUSY high exactly 16 edges then 0; reads of addresses 0..15 all return 0x15 with O_VALID pulses.
2. Masked write: defaults, write A=5 I=0x3F_FFFF_FFFF M=5'b10101, after init to 0 → read A=5 returns 0x3F_00FF_00FF (lanes 0, 2, 4 written; lane 4 covers bits 37:32).
3. Read-before-write: mem[7]=0xAA; same edge CSB=0 WEB=0 OEB=0 A=7 I=0x55 M=all-ones → O=0xAA; next read of A=7 returns 0x55.
4. Latency: OUT_REG=1, back-to-back reads of A=1,2,3 holding 0x11,0x22,0x33 → O=0x11,0x22,0x33 on edges 2,3,4; O_VALID high for those 3 cycles only; O holds 0x33 afterward.
5. Busy/bounds: request write A=3 while BUSY=1 → mem[3] keeps INIT_VAL. DEPTH=12, read A=13 → O=0, O_VALID=1; write A=13 corrupts no word.
6. Reset mid-operation: assert RSTB=0 at sweep count 9, release → BUSY stays high for a full DEPTH edges; a pending OUT_REG=1 read is dropped and O=0 after reset.
